// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - unsigned sequential shift-and-add multiplier
// One partial product per clock through an N-bit add; start/busy/done handshake.
module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [N-1:0]  m_reg, q_reg, a_reg;
  logic [CW-1:0] count;
  logic [N-1:0]  addend, sum;
  logic          c_new, last;
  logic [N-1:0]  a_next, q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    addend     = q_reg[0] ? m_reg : '0;
    {c_new, sum} = {1'b0, a_reg} + {1'b0, addend};
    // The carry is never dropped: it becomes the new MSB of A after the shift.
    a_next     = {c_new, sum[N-1:1]};
    q_next     = {sum[0], q_reg[N-1:1]};
    last       = (count == CW'(N - 1));
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      q_reg   <= '0;
      a_reg   <= '0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            count <= '0;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          count <= count + CW'(1);
          if (last) begin
            product <= {a_next, q_next};
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - directed scoreboard bench for the N=4 and N=8 multiplier
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [3:0]  m4 = '0, q4 = '0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];
  logic [15:0] last_prod[2];

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(m4), .multiplier(q4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  seq_shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [7:0] m, input logic [7:0] q);
    if (w8) begin start8 = s; m8 = m; q8 = q; end
    else    begin start4 = s; m4 = m[3:0]; q4 = q[3:0]; end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction

  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction

  function automatic logic [15:0] get_prod(input bit w8);
    return w8 ? prod8 : {8'h00, prod4};
  endfunction

  // Called at a negedge; pre=1 means start and operands were already driven in the done cycle.
  task automatic run_op(input bit w8, input bit pre, input logic [7:0] m, input logic [7:0] q,
                        input int inj_cyc, input logic [7:0] im, input logic [7:0] iq,
                        input bit chain, input logic [7:0] cm, input logic [7:0] cq,
                        input string tag);
    int n, cyc, bcnt;
    logic [15:0] exp;
    n = w8 ? 8 : 4;
    cyc = 0;
    bcnt = 0;
    if (!pre) begin
      drive(w8, 1'b1, m, q);
      sb.push_back(16'(m) * 16'(q));
    end
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        drive(w8, 1'b0, 8'($urandom), 8'($urandom));
        check({tag, "_prod_held"}, get_prod(w8), last_prod[w8]);
      end
      if (get_busy(w8)) bcnt++;
      if (cyc == inj_cyc) drive(w8, 1'b1, im, iq);
      else if (cyc == inj_cyc + 1) drive(w8, 1'b0, 8'($urandom), 8'($urandom));
    end while (!get_done(w8) && cyc < 40);
    check({tag, "_latency"}, cyc, n + 1);
    check({tag, "_busy_cycles"}, bcnt, n);
    check({tag, "_busy_at_done"}, get_busy(w8), 1'b0);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_product"}, get_prod(w8), exp);
      last_prod[w8] = exp;
    end
    if (chain) begin
      drive(w8, 1'b1, cm, cq);
      sb.push_back(16'(cm) * 16'(cq));
    end else begin
      @(negedge clk);
      check({tag, "_done_pulse"}, get_done(w8), 1'b0);
      check({tag, "_product_stable"}, get_prod(w8), last_prod[w8]);
    end
  endtask

  initial begin
    int dcnt;
    last_prod[0] = '0;
    last_prod[1] = '0;
    repeat (2) @(negedge clk);
    check("reset_busy4", busy4, 1'b0);
    check("reset_done4", done4, 1'b0);
    check("reset_prod4", prod4, 0);
    check("reset_busy8", busy8, 1'b0);
    check("reset_prod8", prod8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 0, 8'd13, 8'd11, -1, 0, 0, 0, 0, 0, "m13q11");
    run_op(0, 0, 8'd15, 8'd15, -1, 0, 0, 0, 0, 0, "m15q15");
    run_op(0, 0, 8'd0,  8'd9,  -1, 0, 0, 0, 0, 0, "m0q9");
    run_op(0, 0, 8'd9,  8'd0,  -1, 0, 0, 0, 0, 0, "m9q0");
    run_op(0, 0, 8'd5,  8'd3,   2, 8'd7, 8'd7, 0, 0, 0, "ignored_req");
    for (int i = 0; i < 4; i++)
      run_op(0, 0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), -1, 0, 0, 0, 0, 0, "rand4");

    // Abort mid-run: outputs must clear asynchronously and no done may follow.
    drive(0, 1'b1, 8'd6, 8'd7);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_prod", prod4, 0);
    last_prod[0] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 || busy4) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    run_op(1, 0, 8'd255, 8'd255, -1, 0, 0, 1, 8'd200, 8'd3, "m255q255");
    run_op(1, 1, 8'd200, 8'd3,   -1, 0, 0, 0, 0, 0, "m200q3_chained");
    run_op(0, 0, 8'd15, 8'd15, -1, 0, 0, 1, 8'd0, 8'd0, "chain4");
    run_op(0, 1, 8'd0, 8'd0, -1, 0, 0, 0, 0, 0, "chain4_zero");

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
